// File: rtl/ppm_tx_scheduler.sv
// Purpose: buffers bytes and serialises each as start/8 data (LSB first)/stop, then a guard gap, onto ppm_din.
// Latency: a byte accepted while idle with an empty buffer drives the start bit from the very next edge.
// Backpressure: tx_ready = !full (low during rst); a sender holding tx_valid while full loses nothing.
module ppm_tx_scheduler #(
    parameter int BIT_CYCLES = 1,
    parameter int GAP_CYCLES = 1356,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          ppm_din,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int MAXC = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] BIT_LOAD = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    // ------------------------------------------------------------------
    // Byte buffer
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full       = (level == LVL_FULL);
    assign empty      = (level == '0);
    assign tx_ready   = !full && !rst;
    assign push       = tx_valid && tx_ready;
    assign fifo_level = level;

    // Storage needs no reset; only pointers and level define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset flushes the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    idx;
    logic [2:0]    idx_nxt;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nxt;
    logic          din_nxt;

    // Next-state logic; cnt holds the cycles remaining in the current bit or gap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                    cnt_nxt   = BIT_LOAD;
                    shreg_nxt = mem[rd_ptr];
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    state_nxt = S_DATA;
                    cnt_nxt   = BIT_LOAD;
                    idx_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    cnt_nxt = BIT_LOAD;
                    if (idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        shreg_nxt = {1'b0, shreg[7:1]};
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_STOP: begin
                if (cnt == '0) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    if (!empty) begin
                        // Back-to-back frame: go straight to the next start bit.
                        pop       = 1'b1;
                        state_nxt = S_START;
                        cnt_nxt   = BIT_LOAD;
                        shreg_nxt = mem[rd_ptr];
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, so ppm_din can be a plain flop.
    always_comb begin
        din_nxt = 1'b1;
        case (state_nxt)
            S_START: din_nxt = 1'b0;
            S_DATA:  din_nxt = shreg_nxt[0];
            default: din_nxt = 1'b1;
        endcase
    end

    // State and registered outputs; reset aborts any frame and idles the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            ppm_din    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shreg      <= shreg_nxt;
            ppm_din    <= din_nxt;
            busy       <= (state_nxt != S_IDLE);
            frame_done <= (state_nxt == S_GAP) && (cnt_nxt == '0);
        end
    end

endmodule

// File: tb/tb_ppm_tx_scheduler.sv
// Purpose: scoreboard bench for ppm_tx_scheduler (BIT_CYCLES=1 and BIT_CYCLES=3 builds, GAP_CYCLES=16, depth 4).
// Latency: expects the start bit one cycle after acceptance and a 26-cycle frame pitch.
// Backpressure: holds tx_valid until tx_ready is seen, so no byte may be lost or duplicated.
module tb_ppm_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ppm_din;
    logic       busy;
    logic       frame_done;
    logic [2:0] fifo_level;

    logic [7:0] tx_data_b;
    logic       tx_valid_b;
    logic       tx_ready_b;
    logic       ppm_din_b;
    logic       busy_b;
    logic       frame_done_b;
    logic [2:0] fifo_level_b;

    always #5 clk = ~clk;

    ppm_tx_scheduler #(.BIT_CYCLES(1), .GAP_CYCLES(16), .FIFO_DEPTH(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ppm_din    (ppm_din),
        .busy       (busy),
        .frame_done (frame_done),
        .fifo_level (fifo_level)
    );

    ppm_tx_scheduler #(.BIT_CYCLES(3), .GAP_CYCLES(16), .FIFO_DEPTH(4)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data_b),
        .tx_valid   (tx_valid_b),
        .tx_ready   (tx_ready_b),
        .ppm_din    (ppm_din_b),
        .busy       (busy_b),
        .frame_done (frame_done_b),
        .fifo_level (fifo_level_b)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         last_acc = 0;
    int         max_lvl = 0;
    int         ready_low = 0;
    int         fd_cnt = 0;
    int         busy_cnt = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_q [$];
    logic [1:0] exp_b [$];
    int         start_log [$];
    logic [9:0] mon_fr;
    logic [7:0] mon_byte;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive a byte and hold it until the handshake edge; the byte joins the scoreboard then.
    task automatic send(input logic [7:0] b);
        int  t;
        bit  ok;
        t = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (1) begin
            ok = tx_ready;
            @(negedge clk);
            if (ok) begin
                exp_q.push_back(b);
                last_acc = cyc;
                break;
            end
            t++;
            if (t > 2000) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || exp_q.size() != 0) && t < 5000);
        if (t >= 5000) check("idle_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    always @(posedge clk) cyc++;

    // Side observers: buffer high-water mark, backpressure and frame_done pulses.
    always @(negedge clk) begin
        if (fifo_level !== 3'bx && int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        if (!rst && tx_valid && !tx_ready) ready_low++;
        if (frame_done === 1'b1) fd_cnt++;
    end

    // Frame monitor: each start bit pops the oldest accepted byte and checks the whole frame and gap.
    always begin
        @(negedge clk);
        if (mon_en && !rst && ppm_din === 1'b0) begin
            start_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_start", 0, 1);
            end else begin
                mon_byte = exp_q.pop_front();
                mon_fr   = {1'b1, mon_byte, 1'b0};
                for (int i = 0; i < 10 && mon_en; i++) begin
                    if (i > 0) @(negedge clk);
                    check($sformatf("byte%02h_bit%0d", mon_byte, i), ppm_din, mon_fr[i]);
                    check("busy_in_frame", busy, 1);
                end
                for (int g = 0; g < 16 && mon_en; g++) begin
                    @(negedge clk);
                    check($sformatf("gap%0d_din", g), ppm_din, 1);
                    check($sformatf("gap%0d_frame_done", g), frame_done, (g == 15));
                end
            end
        end
    end

    initial begin
        int acc0;
        rst        = 1'b1;
        tx_data    = '0;
        tx_valid   = 1'b0;
        tx_data_b  = '0;
        tx_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_din", ppm_din, 1);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", tx_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", tx_ready, 1);
        check("post_rst_din", ppm_din, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_level", fifo_level, 0);
        mon_en = 1'b1;

        // Single byte: latency and frame shape
        start_log.delete();
        send(8'h04);
        tx_valid = 1'b0;
        wait_idle();
        check("t1_frames", start_log.size(), 1);
        if (start_log.size() >= 1) check("t1_latency", start_log[0] - last_acc, 1);
        check("t1_busy_after", busy, 0);

        // Two bytes on consecutive cycles: back-to-back pitch
        start_log.delete();
        send(8'h44);
        send(8'h13);
        tx_valid = 1'b0;
        wait_idle();
        check("t2_frames", start_log.size(), 2);
        if (start_log.size() >= 2) check("t2_pitch", start_log[1] - start_log[0], 26);

        // Six bytes with valid held: fill, backpressure, ordering
        start_log.delete();
        max_lvl   = 0;
        ready_low = 0;
        for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i * 7));
        tx_valid = 1'b0;
        wait_idle();
        check("t3_frames", start_log.size(), 6);
        check("t3_max_level", max_lvl, 4);
        check("t3_ready_dropped", (ready_low > 0), 1);
        check("t3_queue_drained", exp_q.size(), 0);
        for (int i = 1; i < start_log.size(); i++)
            check($sformatf("t3_pitch%0d", i), start_log[i] - start_log[i-1], 26);

        // Reset during DATA bit 3 of 0xFF with two bytes queued
        mon_en = 1'b0;
        send(8'hFF);
        acc0 = last_acc;
        send(8'hAA);
        send(8'hBB);
        tx_valid = 1'b0;
        while (cyc < acc0 + 5) @(negedge clk);
        check("t4_bit3", ppm_din, 1);
        check("t4_level_queued", fifo_level, 2);
        check("t4_busy", busy, 1);
        fd_cnt = 0;
        rst = 1'b1;
        @(negedge clk);
        check("t4_din_rst", ppm_din, 1);
        check("t4_level_rst", fifo_level, 0);
        check("t4_busy_rst", busy, 0);
        check("t4_ready_rst", tx_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("t4_ready_after", tx_ready, 1);
        check("t4_level_after", fifo_level, 0);
        busy_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || !ppm_din) busy_cnt++;
        end
        check("t4_no_stale_frame", busy_cnt, 0);
        check("t4_no_frame_done", fd_cnt, 0);
        exp_q.delete();
        mon_en = 1'b1;
        start_log.delete();
        send(8'h5A);
        tx_valid = 1'b0;
        wait_idle();
        check("t4_fresh_frames", start_log.size(), 1);
        check("t4_fresh_frame_done", fd_cnt, 1);

        // BIT_CYCLES=3 build, byte 0x01
        check("t5_ready", tx_ready_b, 1);
        tx_data_b  = 8'h01;
        tx_valid_b = 1'b1;
        for (int k = 0; k < 46; k++) begin
            logic d;
            d = (k < 3) ? 1'b0 : (k < 6) ? 1'b1 : (k < 27) ? 1'b0 : 1'b1;
            exp_b.push_back({(k == 45), d});
        end
        @(negedge clk);
        tx_valid_b = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 46; k++) begin
            logic [1:0] e;
            e = exp_b.pop_front();
            check($sformatf("t5_sample%0d", k), {frame_done_b, ppm_din_b}, e);
            @(negedge clk);
        end
        check("t5_busy_after", busy_b, 0);
        check("t5_din_after", ppm_din_b, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
